mcu0_intc: RTL

Priority interrupt controller that sits directly upstream of the mcu0 CPU core and drives its `interrupt` and `irq[2:0]` inputs. It collects eight request lines and edge-detects them into a pending register. It masks them with a software-writable enable register, picks the highest-priority source and holds it presented to the core until the core acknowledges. It then blocks further interrupts until the handler signals end-of-interrupt (IRET).

---
 rtl/mcu0_intc_if.sv | 25 ++
 rtl/mcu0_intc.sv | 107 ++++++++++
 2 files changed

// File: rtl/mcu0_intc_if.sv
// Bus between mcu0_intc and its environment: request lines, enable-register
// write port, core ack/eoi handshake, and the controller's outputs.
interface mcu0_intc_if;
    logic [7:0] req;
    logic       en_we;
    logic [7:0] en_wdata;
    logic       ack;
    logic       eoi;
    logic       interrupt;
    logic [2:0] irq;
    logic [7:0] pending;
    logic [7:0] en;
    logic       busy;

    // master: request sources plus the core; slave: the controller itself
    modport master (
        output req, en_we, en_wdata, ack, eoi,
        input  interrupt, irq, pending, en, busy
    );

    modport slave (
        input  req, en_we, en_wdata, ack, eoi,
        output interrupt, irq, pending, en, busy
    );
endinterface

// File: rtl/mcu0_intc.sv
// Eight-source priority interrupt controller feeding the mcu0 core:
// edge-detected pending bits, enable mask, fixed priority, ack/eoi handshake.
module mcu0_intc #(
    parameter logic [7:0] EN_RESET = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    mcu0_intc_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] req_d_q;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] en_q;
    logic       interrupt_q;
    logic       busy_q;
    logic [2:0] irq_q;

    logic [7:0] rise;
    logic [7:0] eligible;
    logic [7:0] clr_mask;
    logic [2:0] winner;
    logic       any_eligible;

    assign rise         = bus.req & ~req_d_q;
    assign eligible     = pending_q & en_q;
    assign any_eligible = |eligible;

    // Scan from the top so the lowest eligible index is the last assignment.
    always_comb begin
        winner = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (eligible[i-1]) begin
                winner = 3'(i - 1);
            end
        end
    end

    // A new rising edge overrides the ack clear on the same bit.
    always_comb begin
        clr_mask = '0;
        if (state_q == S_ASSERT && bus.ack) begin
            clr_mask[irq_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_d_q     <= '0;
            pending_q   <= '0;
            en_q        <= EN_RESET;
            interrupt_q <= 1'b0;
            busy_q      <= 1'b0;
            irq_q       <= '0;
        end else begin
            req_d_q   <= bus.req;
            pending_q <= pending_d;
            if (bus.en_we) begin
                en_q <= bus.en_wdata;
            end

            case (state_q)
                S_IDLE: begin
                    if (any_eligible) begin
                        irq_q       <= winner;
                        interrupt_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (bus.ack) begin
                        interrupt_q <= 1'b0;
                        state_q     <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (bus.eoi) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    interrupt_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.interrupt = interrupt_q;
    assign bus.irq       = irq_q;
    assign bus.pending   = pending_q;
    assign bus.en        = en_q;
    assign bus.busy      = busy_q;

endmodule
